// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage and its helpers.
//   DEF_PC_W / DEF_INSTR_W / DEF_CNT_W : default payload and counter widths
//   DEF_NOP_INSTR                       : instruction presented when the stage is empty
//   ST_EMPTY / ST_ONE / ST_FULL         : stage occupancy encoding as {main_v, skid_v}
package pipe_skid_stage_pkg;

    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_CNT_W   = 16;

    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;

    // {main_v, skid_v}; 2'b01 is never reached
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter for performance statistics.
//   clk : clock
//   rst : synchronous active-low reset, clears the count
//   inc : add one this cycle (ignored once all-ones)
//   cnt : current count
module pipe_skid_stage_sat_counter
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline stage carrying a pc/instruction pair.
//   clk, rst            : clock; synchronous active-low reset
//   flush               : drop every held entry this cycle
//   in_valid/in_ready   : upstream handshake; in_ready is a pure flop output
//   in_pc/in_instr      : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_pc/out_instr    : payload straight from the main register
//   xfer_cnt            : saturating count of completed output transfers
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned           PC_W      = DEF_PC_W,
    parameter int unsigned           INSTR_W   = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter int unsigned           CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   xfer_cnt
);

    logic               main_v_q, main_v_d;
    logic               skid_v_q, skid_v_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic in_fire, out_fire;

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;

    assign in_fire  = in_valid & ~skid_v_q;
    assign out_fire = main_v_q & out_ready;

    always_comb begin
        main_v_d     = main_v_q;
        skid_v_d     = skid_v_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            main_v_d     = 1'b0;
            skid_v_d     = 1'b0;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
        end else begin
            case ({main_v_q, skid_v_q})
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v_d     = 1'b1;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry behind main
                        skid_v_d     = 1'b1;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end else if (out_fire) begin
                        main_v_d     = 1'b0;
                        main_pc_d    = '0;
                        main_instr_d = NOP_INSTR;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        skid_v_d     = 1'b0;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty
                    main_v_d     = 1'b0;
                    skid_v_d     = 1'b0;
                    main_pc_d    = '0;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v_q     <= 1'b0;
            skid_v_q     <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            main_v_q     <= main_v_d;
            skid_v_q     <= skid_v_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    // A transfer completing during flush still counts: downstream took it
    pipe_skid_stage_sat_counter #(
        .CNT_W(CNT_W)
    ) u_xfer_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_fire),
        .cnt(xfer_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam int unsigned CW      = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] xfer_cnt;

    pipe_skid_stage #(
        .PC_W(32),
        .INSTR_W(32),
        .NOP_INSTR(NOP),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the stage is a 2-deep FIFO; entries are {pc, instr}
    logic [63:0] sb[$];
    int unsigned exp_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT against the FIFO model and retire transfers
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
                check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
                check("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
                if (sb.size() == 0) begin
                    check("idle_payload", {out_pc, out_instr}, {32'h0, NOP});
                end else begin
                    check("payload", {out_pc, out_instr}, sb[0]);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    if (exp_cnt < CNT_MAX) exp_cnt++;
                end
            end
        end
    end

    // Drive one cycle; model update lands after the monitor has retired this cycle's output
    task automatic cyc(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit ordy);
        bit acc;
        @(posedge clk);
        #1;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        acc = iv && (sb.size() < 2);
        #6;
        if (!r) begin
            sb.delete();
            exp_cnt = 0;
        end else if (f) begin
            sb.delete();
        end else if (acc) begin
            sb.push_back({pc, ins});
        end
        mon_en = 1'b1;
    endtask

    initial begin : stim
        // Reset held with a live offer
        cyc(0, 0, 1, 32'h100, 32'hB0, 1);
        cyc(0, 0, 1, 32'h100, 32'hB0, 1);
        cyc(1, 0, 1, 32'h100, 32'hB0, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 32'(4 * i), 32'hA0 + 32'(i), 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Backpressure: fill, third offer refused, then drain in order
        cyc(1, 0, 1, 32'h10, 32'hC0, 0);
        cyc(1, 0, 1, 32'h14, 32'hC1, 0);
        cyc(1, 0, 1, 32'h18, 32'hC2, 0);
        cyc(1, 0, 1, 32'h18, 32'hC2, 0);
        cyc(1, 0, 1, 32'h18, 32'hC2, 1);
        cyc(1, 0, 1, 32'h18, 32'hC2, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Flush while full with a same-cycle offer
        cyc(1, 0, 1, 32'h20, 32'hD0, 0);
        cyc(1, 0, 1, 32'h24, 32'hD1, 0);
        cyc(1, 1, 1, 32'h28, 32'hD2, 0);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Reset beats flush
        cyc(1, 0, 1, 32'h30, 32'hE0, 0);
        cyc(0, 1, 1, 32'h34, 32'hE1, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Flush coinciding with an output transfer still counts it
        cyc(1, 0, 1, 32'h40, 32'hE2, 0);
        cyc(1, 1, 0, 32'h0, 32'h0, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Saturation of the narrow counter
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 32'h200 + 32'(4 * i), 32'(i), 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(63) != 0), ($urandom_range(15) == 0),
                ($urandom_range(9) < 7), $urandom, $urandom, ($urandom_range(9) < 6));
        end

        // Drain: everything accepted must have come out
        repeat (4) cyc(1, 0, 0, 32'h0, 32'h0, 1);
        check("drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the plain pc/instruction stage register: a 2-entry elastic (skid) pipeline stage with valid/ready handshake on both sides, flush, and a transfer counter.
- Sits between any two pipeline stages (IF/ID … MEM/WB).
- Upstream stalls never combinationally depend on downstream ready.
- Sustains full throughput at 1 transfer/cycle.

Parameters:
- PC_W, 32, width of pc payload field.
- INSTR_W, 32, width of instruction payload field.
- NOP_INSTR, {INSTR_W{1'b0}}, instruction value driven when stage empty, flushed or in reset.
- CNT_W, 16, width of saturating output-transfer counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on posedge clk).
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream offers payload.
- in_ready  out  1  stage can accept; registered-only (no combinational path from out_ready).
- in_pc  in  PC_W  upstream pc.
- in_instr  in  INSTR_W  upstream instruction.
- out_valid  out  1  stage presents payload.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  presented pc.
- out_instr  out  INSTR_W  presented instruction.
- xfer_cnt  out  CNT_W  count of completed output transfers, saturating.

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register.
- State is encoded by main_v/skid_v: EMPTY (0/0), ONE (1/0), FULL (1/1). Skid valid with main invalid is illegal.
- in_ready = !skid_v. out_valid = main_v.
- out_pc/out_instr come directly from main register flops; no output mux.
- Reset (rst==0 at posedge): state EMPTY; in_ready=1; out_valid=0; out_pc=0; out_instr=NOP_INSTR; xfer_cnt=0. Reset overrides flush and all transfers.
- Flush (rst==1, flush==1): next state EMPTY.
  - Main pc <= 0, instr <= NOP_INSTR.
  - Same-cycle in_fire payload is dropped.
  - A same-cycle out_fire still counts in xfer_cnt, since downstream consumed it.
- State transitions when no reset and no flush:
  - EMPTY + in_fire -> ONE, main <= in. Latency in->out is 1 cycle.
  - ONE + in_fire + out_fire -> ONE, main <= in. This is the full-throughput case.
  - ONE + in_fire + !out_fire -> FULL, skid <= in, main held.
  - ONE + !in_fire + out_fire -> EMPTY, main payload <= 0/NOP_INSTR.
  - FULL (in_ready=0) + out_fire -> ONE, main <= skid.
  - Any other combination: hold.
- Stability: while out_valid & !out_ready, out_pc/out_instr must not change.
- Ordering is strictly FIFO; no entry duplicated or lost except on flush.
- xfer_cnt increments by 1 on each out_fire and saturates at all-ones (no wrap).
- Payload registers are not cleared on transitions that keep them valid.

Decomposition:
- Shared package holds:
  - default widths (PC_W=32, INSTR_W=32);
  - NOP_INSTR constant;
  - stage state encoding localparams (ST_EMPTY, ST_ONE, ST_FULL) for bench visibility.
- One natural sub-module: sat_counter (CNT_W, synchronous active-low rst, inc input), reused by other stages' performance counters.
- The skid logic remains in the top module.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_valid=1, in_pc=0x100 -> out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, xfer_cnt=0; after release, first accepted item appears on the next cycle.
2. Streaming: out_ready=1, push pc=0x0,0x4,0x8,0xC with instr=0xA0..0xA3 back-to-back -> out_* matches each item one cycle later, no bubbles, xfer_cnt=4.
3. Backpressure: out_ready=0, push 0x10 then 0x14 -> out holds 0x10 stable, in_ready=0 after 2nd accept, 3rd offer 0x18 not accepted; raise out_ready -> outputs 0x10, 0x14, then 0x18 in order.
4. Flush in FULL: state FULL (0x20 main, 0x24 skid), assert flush with in_valid=1 pc=0x28 -> next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1; 0x20/0x24/0x28 never appear.
5. Flush and reset priority: flush=1 with rst=0 -> reset values (xfer_cnt=0); flush=1 coinciding with out_fire -> xfer_cnt increments by 1.
6. Saturation: CNT_W=4, stream 20 items -> xfer_cnt reaches 15 and stays 15.
